sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Two-requester arbiter sharing one single-port sram instance (combinational read, negedge write) between the instruction-fetch port (port 0) and the load/store port (port 1).
- Grants at most one access per clock using round-robin priority, with an optional lock for back-to-back bursts.
- Drives the sram en/we/addr/wr_data pins and returns registered read data with a valid pulse to the winning requester.

Parameters:
- addr_width, 16, sram address width
- data_width, 32, sram data width

Ports:
- clk  in  1  system clock; posedge logic, sram writes on negedge
- rst  in  1  synchronous active-high reset
- req0_valid  in  1  port 0 access request
- req0_we  in  1  port 0 write (1) / read (0)
- req0_lock  in  1  port 0 keeps grant while asserted
- req0_addr  in  addr_width  port 0 address
- req0_wdata  in  data_width  port 0 write data
- req0_ready  out  1  port 0 granted this cycle (combinational)
- rsp0_valid  out  1  port 0 read data valid
- rsp0_data  out  data_width  port 0 read data
- req1_valid, req1_we, req1_lock, req1_addr, req1_wdata, req1_ready, rsp1_valid, rsp1_data: same as port 0, for port 1
- mem_en  out  1  to sram en
- mem_we  out  1  to sram we
- mem_addr  out  addr_width  to sram addr
- mem_wr_data  out  data_width  to sram wr_data
- mem_rd_data  in  data_width  from sram data

Behaviour:
- Handshake: a request transfers in any cycle where reqN_valid && reqN_ready.
  - Requesters hold valid, we, addr and wdata stable until ready.
  - reqN_ready depends combinationally on the valids, the lock state and last_grant only, never on data.
- Arbitration (combinational grant; state is last_grant and lock_owner):
  - Locked: lock_owner valid and that port's valid high → grant the owner.
  - Only one valid → grant it.
  - Both valid → grant the port != last_grant.
  - Neither valid → no grant.
- Posedge updates:
  - On any grant: last_grant <= granted port.
  - If the granted port has lock high: lock_owner <= that port.
  - Lock release: lock_owner cleared when the owner's lock or valid is low in a cycle; the same cycle arbitrates normally.
- Memory pins, all combinational from the granted request:
  - Grant present: mem_en=1, mem_we=granted we, mem_addr/mem_wr_data = granted fields.
  - No grant: mem_en=0, mem_we=0, mem_addr=0, mem_wr_data=0.
- Read latency 1:
  - At the posedge ending a granted read cycle: rspN_data <= mem_rd_data and rspN_valid <= 1 for that port.
  - rspN_valid is 0 otherwise and is a one-cycle pulse per read.
  - rspN_data holds its last value when not valid.
- Writes:
  - Complete at the negedge inside the grant cycle.
  - No rsp pulse; ready is the only acknowledgement.
- Read-after-write to the same address in consecutive grants returns the new data, because the write lands before the next cycle's combinational read.
- Reset, synchronous, takes priority over everything:
  - last_grant <= 1, so port 0 wins the first contention.
  - lock_owner <= none.
  - rsp0_valid = rsp1_valid = 0; rsp0_data = rsp1_data = 0.
  - While rst is high: both ready = 0, mem_en = 0, mem_we = 0.
  - An access in flight when rst rises is dropped and produces no response.
- Fairness: with both requesters continuously valid and no lock, grants alternate 0,1,0,1…
  - A locked owner may starve the other port indefinitely; this is intended for bursts.

Test Plan:
- Reset, then port 0 only: read addr 0x0010 preloaded 0xDEADBEEF → req0_ready=1 that cycle; next cycle rsp0_valid=1, rsp0_data=0xDEADBEEF; rsp1_valid stays 0.
- Both ports valid for 4 cycles after reset, no lock: port0 reads 0x0001, port1 reads 0x0002 → grants 0,1,0,1; mem_addr sequence 0x0001,0x0002,0x0001,0x0002.
- Port 1 writes 0x12345678 to 0x0040, then port 0 reads 0x0040 the next cycle → rsp0_data=0x12345678; mem_we=1 only in the write cycle.
- Port 1 with lock high and valid for 3 cycles while port 0 is valid → port 1 granted 3 consecutive cycles; after lock drops, port 0 is granted the next cycle.
- Assert rst during a granted port 0 read → no rsp0_valid next cycle; mem_en=0 while reset is high; first contention afterward is granted to port 0.
- Idle, both valid low → mem_en=0, mem_we=0, mem_addr=0, both ready=0, no rsp pulses.

Source files
------------

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter sharing one single-port sram between fetch (port 0) and load/store (port 1).
// Latency: grant and sram pins are combinational in the request cycle; read data returns one cycle later.
// Backpressure: reqN_ready is low for the losing/locked-out port; the requester holds its request until ready.
module sram_arbiter #(
    parameter int addr_width = 16,
    parameter int data_width = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req0_valid,
    input  logic                  req0_we,
    input  logic                  req0_lock,
    input  logic [addr_width-1:0] req0_addr,
    input  logic [data_width-1:0] req0_wdata,
    output logic                  req0_ready,
    output logic                  rsp0_valid,
    output logic [data_width-1:0] rsp0_data,

    input  logic                  req1_valid,
    input  logic                  req1_we,
    input  logic                  req1_lock,
    input  logic [addr_width-1:0] req1_addr,
    input  logic [data_width-1:0] req1_wdata,
    output logic                  req1_ready,
    output logic                  rsp1_valid,
    output logic [data_width-1:0] rsp1_data,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [addr_width-1:0] mem_addr,
    output logic [data_width-1:0] mem_wr_data,
    input  logic [data_width-1:0] mem_rd_data
);

    // Arbitration state: port granted most recently, and the current lock holder (if any).
    logic last_grant;
    logic lock_held;
    logic lock_owner;

    // Combinational view of the lock owner's live request.
    logic owner_valid;
    logic owner_lock;
    logic locked;

    // Per-cycle grant decision and the fields of the winning request.
    logic                  grant0;
    logic                  grant1;
    logic                  grant_any;
    logic                  sel_we;
    logic                  sel_lock;
    logic [addr_width-1:0] sel_addr;
    logic [data_width-1:0] sel_wdata;

    // Lock is honoured only while the owner keeps both valid and lock high;
    // a dropped lock lets the same cycle fall through to round-robin.
    always_comb begin
        owner_valid = lock_owner ? req1_valid : req0_valid;
        owner_lock  = lock_owner ? req1_lock  : req0_lock;
        locked      = lock_held && owner_valid && owner_lock;
    end

    // Grant selection: lock first, then single requester, then round-robin on contention.
    // Reset suppresses every grant so nothing reaches the sram while rst is high.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (locked) begin
                grant0 = ~lock_owner;
                grant1 = lock_owner;
            end else if (req0_valid && req1_valid) begin
                grant0 = last_grant;
                grant1 = ~last_grant;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign grant_any  = grant0 | grant1;
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Mux the winning request's fields; only port 1 or port 0 can win in a cycle.
    always_comb begin
        sel_we    = grant1 ? req1_we    : req0_we;
        sel_lock  = grant1 ? req1_lock  : req0_lock;
        sel_addr  = grant1 ? req1_addr  : req0_addr;
        sel_wdata = grant1 ? req1_wdata : req0_wdata;
    end

    // Sram pins: driven from the granted request, all-zero when idle so the bus is quiet.
    always_comb begin
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        if (grant_any) begin
            mem_en      = 1'b1;
            mem_we      = sel_we;
            mem_addr    = sel_addr;
            mem_wr_data = sel_wdata;
        end
    end

    // Arbitration state update: remember the winner, take or release the lock.
    // A fresh lock from the winner takes precedence over releasing a stale one.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            lock_held  <= 1'b0;
            lock_owner <= 1'b0;
        end else begin
            if (grant_any) begin
                last_grant <= grant1;
            end
            if (grant_any && sel_lock) begin
                lock_held  <= 1'b1;
                lock_owner <= grant1;
            end else if (lock_held && !(owner_valid && owner_lock)) begin
                lock_held <= 1'b0;
            end
        end
    end

    // Port 0 read response: capture sram data at the end of a granted read, one-cycle valid pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp0_valid <= 1'b0;
            rsp0_data  <= '0;
        end else begin
            rsp0_valid <= grant0 && !req0_we;
            if (grant0 && !req0_we) begin
                rsp0_data <= mem_rd_data;
            end
        end
    end

    // Port 1 read response: same scheme as port 0; data holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp1_valid <= 1'b0;
            rsp1_data  <= '0;
        end else begin
            rsp1_valid <= grant1 && !req1_we;
            if (grant1 && !req1_we) begin
                rsp1_data <= mem_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed stimulus with a per-cycle expectation queue and per-port response queues.
// Stimulus drives one request pair per cycle; a monitor on the falling edge pops and compares.
// Includes a behavioural sram (combinational read, negedge write).
module tb_sram_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;

    typedef struct {
        logic          v;
        logic          we;
        logic          lk;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
    } req_t;

    typedef struct {
        int            idx;
        logic          r0;
        logic          r1;
        logic          en;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic          rz;
    } exp_t;

    typedef struct {
        int            due;
        logic [DW-1:0] d;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0, req0_we = 1'b0, req0_lock = 1'b0;
    logic [AW-1:0] req0_addr = '0;
    logic [DW-1:0] req0_wdata = '0;
    logic          req0_ready, rsp0_valid;
    logic [DW-1:0] rsp0_data;
    logic          req1_valid = 1'b0, req1_we = 1'b0, req1_lock = 1'b0;
    logic [AW-1:0] req1_addr = '0;
    logic [DW-1:0] req1_wdata = '0;
    logic          req1_ready, rsp1_valid;
    logic [DW-1:0] rsp1_data;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wr_data, mem_rd_data;

    logic [DW-1:0] sram [0:(1<<AW)-1];

    int   cyc = 0;
    int   nstep = 0;
    int   cur = 0;
    int   checks = 0;
    int   failures = 0;
    logic done = 1'b0;

    exp_t exp_q[$];
    rsp_t q0[$];
    rsp_t q1[$];

    sram_arbiter #(.addr_width(AW), .data_width(DW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_lock(req0_lock),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_lock(req1_lock),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural sram: read is combinational, write lands on the falling edge.
    assign mem_rd_data = sram[mem_addr];
    always @(negedge clk) begin
        if (mem_en && mem_we) sram[mem_addr] <= mem_wr_data;
    end

    function automatic req_t mk(input logic v, input logic we, input logic lk,
                                input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_t r;
        r.v = v; r.we = we; r.lk = lk; r.addr = a; r.wd = d;
        return r;
    endfunction

    // One stimulus cycle; g is the hand-computed winner (-1 none), rexp the read data it must return.
    task automatic step(input logic r, input req_t a, input req_t b, input int g,
                        input logic [DW-1:0] rexp, input logic rz);
        exp_t e;
        @(posedge clk);
        #1;
        rst        = r;
        req0_valid = a.v; req0_we = a.we; req0_lock = a.lk; req0_addr = a.addr; req0_wdata = a.wd;
        req1_valid = b.v; req1_we = b.we; req1_lock = b.lk; req1_addr = b.addr; req1_wdata = b.wd;
        e.idx = nstep; e.r0 = 1'b0; e.r1 = 1'b0; e.en = 1'b0; e.we = 1'b0;
        e.addr = '0; e.wd = '0; e.rz = rz;
        if (g == 0) begin
            e.r0 = 1'b1; e.en = 1'b1; e.we = a.we; e.addr = a.addr; e.wd = a.wd;
            if (!a.we) q0.push_back('{cyc + 1, rexp});
        end else if (g == 1) begin
            e.r1 = 1'b1; e.en = 1'b1; e.we = b.we; e.addr = b.addr; e.wd = b.wd;
            if (!b.we) q1.push_back('{cyc + 1, rexp});
        end
        exp_q.push_back(e);
        nstep++;
    endtask

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s step=%0d actual=%h required=%h", n, cur, act, req);
        end
    endtask

    // Stimulus: directed vectors, winners and read data computed by hand.
    initial begin
        req_t idle, r0a, r1a, l1;
        idle = mk(0, 0, 0, 16'h0000, 32'h0);
        for (int i = 0; i < (1 << AW); i++) sram[i] = '0;
        sram[16'h0010] = 32'hDEADBEEF;
        sram[16'h0001] = 32'h11111111;
        sram[16'h0002] = 32'h22222222;

        // reset
        step(1, idle, idle, -1, 0, 0);
        step(1, idle, idle, -1, 0, 0);
        // single port-0 read, then idle cycle
        step(0, mk(1, 0, 0, 16'h0010, 0), idle, 0, 32'hDEADBEEF, 1);
        step(0, idle, idle, -1, 0, 0);
        // reset again, then contention: 0,1,0,1
        step(1, idle, idle, -1, 0, 0);
        r0a = mk(1, 0, 0, 16'h0001, 0);
        r1a = mk(1, 0, 0, 16'h0002, 0);
        step(0, r0a, r1a, 0, 32'h11111111, 1);
        step(0, r0a, r1a, 1, 32'h22222222, 0);
        step(0, r0a, r1a, 0, 32'h11111111, 0);
        step(0, r0a, r1a, 1, 32'h22222222, 0);
        // write by port 1, read-after-write by port 0
        step(0, idle, mk(1, 1, 0, 16'h0040, 32'h12345678), 1, 0, 0);
        step(0, mk(1, 0, 0, 16'h0040, 0), idle, 0, 32'h12345678, 0);
        // port 1 lock burst against a waiting port 0, then release
        l1 = mk(1, 0, 1, 16'h0002, 0);
        step(0, r0a, l1, 1, 32'h22222222, 0);
        step(0, r0a, l1, 1, 32'h22222222, 0);
        step(0, r0a, l1, 1, 32'h22222222, 0);
        step(0, r0a, r1a, 0, 32'h11111111, 0);
        step(0, idle, r1a, 1, 32'h22222222, 0);
        // reset during requests: dropped, write suppressed, port 0 wins first contention
        step(0, mk(1, 0, 0, 16'h0010, 0), idle, 0, 32'hDEADBEEF, 0);
        step(1, mk(1, 0, 0, 16'h0010, 0), mk(1, 1, 0, 16'h0040, 32'hBAD0BAD0), -1, 0, 0);
        step(0, mk(1, 0, 0, 16'h0040, 0), r1a, 0, 32'h12345678, 1);
        step(0, idle, r1a, 1, 32'h22222222, 0);
        // drain
        step(0, idle, idle, -1, 0, 0);
        step(0, idle, idle, -1, 0, 0);
        step(0, idle, idle, -1, 0, 0);
        done = 1'b1;
    end

    // Monitor: compares pins each stimulus cycle and matches response pulses against the queues.
    initial begin
        exp_t e;
        rsp_t r;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cur = e.idx;
                chk("req0_ready", {63'd0, req0_ready}, {63'd0, e.r0});
                chk("req1_ready", {63'd0, req1_ready}, {63'd0, e.r1});
                chk("mem_en", {63'd0, mem_en}, {63'd0, e.en});
                chk("mem_we", {63'd0, mem_we}, {63'd0, e.we});
                chk("mem_addr", {48'd0, mem_addr}, {48'd0, e.addr});
                chk("mem_wr_data", {32'd0, mem_wr_data}, {32'd0, e.wd});
                if (e.rz) begin
                    chk("rsp0_data_reset", {32'd0, rsp0_data}, 64'd0);
                    chk("rsp1_data_reset", {32'd0, rsp1_data}, 64'd0);
                end
            end
            if (rsp0_valid === 1'b1) begin
                if (q0.size() == 0) chk("rsp0_unexpected", 64'd1, 64'd0);
                else begin
                    r = q0.pop_front();
                    chk("rsp0_cycle", 64'(cyc), 64'(r.due));
                    chk("rsp0_data", {32'd0, rsp0_data}, {32'd0, r.d});
                end
            end else if (rsp0_valid !== 1'b0) chk("rsp0_valid_x", {63'd0, rsp0_valid}, 64'd0);
            if (q0.size() > 0 && q0[0].due < cyc) begin
                r = q0.pop_front();
                chk("rsp0_missing", 64'(cyc), 64'(r.due));
            end
            if (rsp1_valid === 1'b1) begin
                if (q1.size() == 0) chk("rsp1_unexpected", 64'd1, 64'd0);
                else begin
                    r = q1.pop_front();
                    chk("rsp1_cycle", 64'(cyc), 64'(r.due));
                    chk("rsp1_data", {32'd0, rsp1_data}, {32'd0, r.d});
                end
            end else if (rsp1_valid !== 1'b0) chk("rsp1_valid_x", {63'd0, rsp1_valid}, 64'd0);
            if (q1.size() > 0 && q1[0].due < cyc) begin
                r = q1.pop_front();
                chk("rsp1_missing", 64'(cyc), 64'(r.due));
            end
            if (done && exp_q.size() == 0) break;
        end
        chk("rsp0_left", 64'(q0.size()), 64'd0);
        chk("rsp1_left", 64'(q1.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog against a stalled run.
    initial begin
        #100000;
        $display("FAIL watchdog step=%0d actual=timeout required=finish", cur);
        $fatal(1, "timeout");
    end

endmodule
